md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- Execute-stage multiply/divide unit of the 5-stage MIPS pipeline.
- Consumes the forwarded E-stage operands, i.e. the outputs of the ALU A/B forwarding muxes, which are selected by the forwarding controller.
- Owns the HI/LO registers and models multi-cycle MULT/DIV latency with a busy counter.
- Generates the D-stage stall request for instructions that touch HI/LO while an operation is in flight.

Parameters:
- MULT_CYCLES, 5, cycles busy is held after a MULT/MULTU start (must be ≥1).
- DIV_CYCLES, 10, cycles busy is held after a DIV/DIVU start (must be ≥1).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  E-stage instruction is a valid HI/LO operation this cycle.
- md_op  input  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE).
- op_a  input  32  forwarded rs value (ALU A after forwarding).
- op_b  input  32  forwarded rt value (ALU B after forwarding).
- md_use_d  input  1  D-stage instruction is MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO.
- busy  output  1  multi-cycle operation in flight.
- hi  output  32  HI register (read by MFHI in E).
- lo  output  32  LO register (read by MFLO in E).
- stall_md  output  1  D-stage stall request.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on reset_n. While reset_n = 0: hi = 0, lo = 0, busy = 0, state IDLE, counter = 0.
- Reset mid-operation aborts the operation. The pending result is discarded; it is never written to HI/LO.
- FSM has two states, IDLE and BUSY.
- IDLE, start=1, md_op ∈ {1..4}:
  - Latch the pending result.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
  - Go to BUSY; busy=1 from the next cycle.
- IDLE, start=1, md_op=5 (MTHI): hi ← op_a at the edge; no busy.
- IDLE, start=1, md_op=6 (MTLO): lo ← op_a at the edge; no busy.
- IDLE, start=1, md_op ∈ {0,7}: no effect.
- BUSY: counter decrements every cycle.
  - When counter = 1: pending {hi,lo} committed at that edge, busy drops to 0 at the same edge, return to IDLE.
  - Consequence: hi/lo are valid and busy=0 exactly N cycles after the start edge.
- Start while BUSY is ignored; state and HI/LO are unchanged. The hazard logic must prevent this; the bench asserts it never happens in system tests.
- Arithmetic:
  - MULT: signed 32×32→64; hi = [63:32], lo = [31:0].
  - MULTU: unsigned 32×32→64; same split.
  - DIV: signed; lo = quotient truncated toward zero; hi = remainder, with the sign of the dividend.
  - DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
  - DIVU: unsigned quotient in lo, remainder in hi.
  - Divide by zero (DIV or DIVU): busy sequence runs normally; HI/LO keep their prior values at commit.
- Operands are sampled only at the start edge. Later changes on op_a/op_b do not affect the result.
- hi/lo are register outputs; MFHI/MFLO in E see the committed values only.
- stall_md = md_use_d & (busy | (start & md_op ∈ {1..4})). It is combinational and holds D until the cycle busy falls.
- No flush input: operations already started always complete.

Test Plan:
1. Reset then idle: reset_n low mid-run → hi=0, lo=0, busy=0 immediately (asynchronous, no clock edge needed).
2. MULT op_a=0xFFFFFFFE (−2), op_b=3 → busy high for exactly 5 cycles; afterwards hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands → hi=0x00000002, lo=0xFFFFFFFA.
3. DIV −7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF after exactly 10 cycles. DIVU 7/2 → lo=3, hi=1. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0. DIV x/0 → hi/lo unchanged.
4. MTHI op_a=0x12345678 then MTLO op_a=0x9ABCDEF0 on consecutive cycles → hi/lo updated at each edge, busy stays 0, stall_md=0.
5. MULT start with md_use_d=1 → stall_md=1 in the start cycle and all 5 busy cycles, 0 the cycle after commit. A second start during busy → ignored; first result intact.
6. reset_n pulsed low at busy cycle 3 of a DIV → busy=0, hi=lo=0. Counter restarts cleanly on the next start.

Source files
------------

// File: rtl/md_unit.sv
// md_unit: execute-stage MIPS multiply/divide unit owning HI/LO with modelled latency.
//   clk, reset_n          : rising-edge clock, asynchronous active-low reset
//   start, md_op          : valid HI/LO op in E (1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO)
//   op_a, op_b            : forwarded rs/rt operands, sampled only at the start edge
//   md_use_d              : D-stage instruction touches HI/LO
//   busy, hi, lo          : in-flight flag and registered HI/LO
//   stall_md              : combinational D-stage stall request
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        md_use_d,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        stall_md
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam int MAX_CYCLES = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);
    logic [0:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [31:0]        hi_q, hi_d, lo_q, lo_d;
    logic [31:0]        res_hi_q, res_hi_d, res_lo_q, res_lo_d;
    logic               res_we_q, res_we_d;
    logic               is_div, is_md, div_ovf, div_zero;
    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        sdiv_b, udiv_b;
    logic signed [31:0] squot, srem;
    logic [31:0]        uquot, urem;
    logic [31:0]        new_hi, new_lo;
    assign is_div   = md_op == OP_DIV || md_op == OP_DIVU;
    assign is_md    = md_op == OP_MULT || md_op == OP_MULTU || is_div;
    assign div_zero = op_b == 32'd0;
    // INT_MIN / -1 overflows; dividing by 1 instead yields the required lo=INT_MIN, hi=0.
    // Divide-by-zero also uses 1 so the dividers never see 0; that result is never committed.
    assign div_ovf  = op_a == 32'h8000_0000 && op_b == 32'hFFFF_FFFF;
    assign sdiv_b   = (div_zero || div_ovf) ? 32'd1 : op_b;
    assign udiv_b   = div_zero ? 32'd1 : op_b;
    assign prod_s   = $signed({{32{op_a[31]}}, op_a}) * $signed({{32{op_b[31]}}, op_b});
    assign prod_u   = {32'd0, op_a} * {32'd0, op_b};
    assign squot    = $signed(op_a) / $signed(sdiv_b);
    assign srem     = $signed(op_a) % $signed(sdiv_b);
    assign uquot    = op_a / udiv_b;
    assign urem     = op_a % udiv_b;
    assign new_hi   = md_op == OP_MULT  ? prod_s[63:32] :
                      md_op == OP_MULTU ? prod_u[63:32] :
                      md_op == OP_DIV   ? srem : urem;
    assign new_lo   = md_op == OP_MULT  ? prod_s[31:0] :
                      md_op == OP_MULTU ? prod_u[31:0] :
                      md_op == OP_DIV   ? squot : uquot;
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        res_we_d = res_we_q;
        if (state_q == IDLE) begin
            if (start && is_md) begin
                state_d  = BUSY;
                cnt_d    = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                res_hi_d = new_hi;
                res_lo_d = new_lo;
                res_we_d = !(is_div && div_zero);
            end else if (start && md_op == OP_MTHI) begin
                hi_d = op_a;
            end else if (start && md_op == OP_MTLO) begin
                lo_d = op_a;
            end
        end else begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
                state_d = IDLE;
                hi_d    = res_we_q ? res_hi_q : hi_q;
                lo_d    = res_we_q ? res_lo_q : lo_q;
            end
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            res_we_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            res_we_q <= res_we_d;
        end
    end
    assign busy     = state_q == BUSY;
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign stall_md = md_use_d && (busy || (start && is_md));
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed bench for md_unit with a per-cycle reference model and literal checks.
module tb_md_unit;
    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        md_use_d = 1'b0;
    logic [2:0]  md_op = 3'd0;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic        busy, stall_md;
    logic [31:0] hi, lo;
    int errors = 0;
    int checks = 0;

    md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .md_op(md_op),
        .op_a(op_a), .op_b(op_b), .md_use_d(md_use_d),
        .busy(busy), .hi(hi), .lo(lo), .stall_md(stall_md)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: an operation started at edge number c finishes at edge c+N.
    longint      cyc = 0;
    longint      done_at = 0;
    logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
    bit          p_we = 0;
    longint      sa, sb, q, r;
    logic [63:0] prod;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_hi = 0; m_lo = 0; done_at = 0; p_we = 0;
        end else begin
            if (cyc < done_at) begin
                if (cyc + 1 == done_at && p_we) begin m_hi = p_hi; m_lo = p_lo; end
            end else if (start) begin
                sa = longint'($signed(op_a));
                sb = longint'($signed(op_b));
                case (md_op)
                    3'd1: begin prod = sa * sb; {p_hi, p_lo} = prod; p_we = 1; done_at = cyc + 1 + MULT_N; end
                    3'd2: begin prod = {32'd0, op_a} * {32'd0, op_b}; {p_hi, p_lo} = prod; p_we = 1; done_at = cyc + 1 + MULT_N; end
                    3'd3: begin
                        p_we = op_b != 0;
                        if (p_we) begin q = sa / sb; r = sa % sb; p_lo = q[31:0]; p_hi = r[31:0]; end
                        done_at = cyc + 1 + DIV_N;
                    end
                    3'd4: begin
                        p_we = op_b != 0;
                        if (p_we) begin p_lo = op_a / op_b; p_hi = op_a % op_b; end
                        done_at = cyc + 1 + DIV_N;
                    end
                    3'd5: m_hi = op_a;
                    3'd6: m_lo = op_a;
                    default: ;
                endcase
            end
            cyc++;
        end
    end

    always @(negedge clk) begin
        logic eb, es;
        eb = cyc < done_at;
        es = md_use_d && (eb || (start && md_op >= 3'd1 && md_op <= 3'd4));
        chk("model_busy", 32'(busy), 32'(eb));
        chk("model_stall", 32'(stall_md), 32'(es));
        chk("model_hi", hi, m_hi);
        chk("model_lo", lo, m_lo);
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        start = 1; md_op = op; op_a = a; op_b = b;
        @(posedge clk); #1;
        start = 0; md_op = 0; op_a = $urandom; op_b = $urandom;
    endtask

    task automatic wait_idle(input string nm, input int exp_n);
        int n = 0;
        while (busy === 1'b1 && n < 64) begin @(posedge clk); #1; n++; end
        chk(nm, n, exp_n);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hi", hi, 0); chk("rst_lo", lo, 0); chk("rst_busy", 32'(busy), 0);
        reset_n = 1;
        @(posedge clk); #1;
        start = 1; md_op = 5; op_a = 32'h12345678; md_use_d = 1;
        #1 chk("mthi_stall", 32'(stall_md), 0);
        @(posedge clk); #1;
        chk("mthi_hi", hi, 32'h12345678); chk("mthi_busy", 32'(busy), 0);
        md_op = 6; op_a = 32'h9ABCDEF0;
        #1 chk("mtlo_stall", 32'(stall_md), 0);
        @(posedge clk); #1;
        chk("mtlo_lo", lo, 32'h9ABCDEF0); chk("mtlo_hi", hi, 32'h12345678); chk("mtlo_busy", 32'(busy), 0);
        start = 0; md_op = 0; md_use_d = 0;
        #2 reset_n = 0;
        #1 chk("async_hi", hi, 0); chk("async_lo", lo, 0); chk("async_busy", 32'(busy), 0);
        #1 reset_n = 1;
        @(posedge clk); #1;
        issue(1, 32'hFFFFFFFE, 32'd3);
        wait_idle("mult_cycles", MULT_N);
        chk("mult_hi", hi, 32'hFFFFFFFF); chk("mult_lo", lo, 32'hFFFFFFFA);
        issue(2, 32'hFFFFFFFE, 32'd3);
        wait_idle("multu_cycles", MULT_N);
        chk("multu_hi", hi, 32'h00000002); chk("multu_lo", lo, 32'hFFFFFFFA);
        issue(2, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_idle("multu_max_cycles", MULT_N);
        chk("multu_max_hi", hi, 32'hFFFFFFFE); chk("multu_max_lo", lo, 32'h00000001);
        issue(1, 32'h80000000, 32'h80000000);
        wait_idle("mult_min_cycles", MULT_N);
        chk("mult_min_hi", hi, 32'h40000000); chk("mult_min_lo", lo, 32'h00000000);
        issue(3, 32'hFFFFFFF9, 32'd2);
        wait_idle("div_cycles", DIV_N);
        chk("div_hi", hi, 32'hFFFFFFFF); chk("div_lo", lo, 32'hFFFFFFFD);
        issue(4, 32'd7, 32'd2);
        wait_idle("divu_cycles", DIV_N);
        chk("divu_hi", hi, 32'd1); chk("divu_lo", lo, 32'd3);
        issue(3, 32'h80000000, 32'hFFFFFFFF);
        wait_idle("div_ovf_cycles", DIV_N);
        chk("div_ovf_hi", hi, 32'd0); chk("div_ovf_lo", lo, 32'h80000000);
        issue(3, 32'd5, 32'd0);
        wait_idle("div0_cycles", DIV_N);
        chk("div0_hi", hi, 32'd0); chk("div0_lo", lo, 32'h80000000);
        issue(4, 32'd9, 32'd0);
        wait_idle("divu0_cycles", DIV_N);
        chk("divu0_hi", hi, 32'd0); chk("divu0_lo", lo, 32'h80000000);
        start = 1; md_op = 1; op_a = 32'hFFFFFFFF; op_b = 32'd5; md_use_d = 1;
        #1 chk("stall_start", 32'(stall_md), 1);
        @(posedge clk); #1;
        for (int i = 0; i < MULT_N; i++) begin
            if (i == 1) begin start = 1; md_op = 3; op_a = 32'd100; op_b = 32'd3; end
            else begin start = 0; md_op = 0; end
            #1 chk("stall_busy", 32'(stall_md), 1); chk("busy_held", 32'(busy), 1);
            @(posedge clk); #1;
        end
        start = 0; md_op = 0;
        #1 chk("stall_after", 32'(stall_md), 0); chk("busy_after", 32'(busy), 0);
        chk("ignored_hi", hi, 32'hFFFFFFFF); chk("ignored_lo", lo, 32'hFFFFFFFB);
        md_use_d = 0;
        @(posedge clk); #1;
        issue(3, 32'd100, 32'd7);
        repeat (2) @(posedge clk);
        #2 reset_n = 0;
        #1 chk("abort_busy", 32'(busy), 0); chk("abort_hi", hi, 0); chk("abort_lo", lo, 0);
        #1 reset_n = 1;
        repeat (DIV_N + 2) @(posedge clk);
        #1 chk("abort_lo_later", lo, 0); chk("abort_busy_later", 32'(busy), 0);
        issue(2, 32'd3, 32'd4);
        wait_idle("restart_cycles", MULT_N);
        chk("restart_hi", hi, 0); chk("restart_lo", lo, 32'd12);
        issue(3, 32'd100, 32'd7);
        wait_idle("div2_cycles", DIV_N);
        chk("div2_hi", hi, 32'd2); chk("div2_lo", lo, 32'd14);
        @(posedge clk); #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
